hms_time_counter: RTL and testbench



---
 rtl/hms_pkg.sv | 15 +
 rtl/hms_time_counter_mod_counter.sv | 31 +++
 rtl/hms_time_counter.sv | 100 ++++++++++
 tb/tb_hms_time_counter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hms_pkg.sv
// hms_pkg: shared types and constants for the hours/minutes/seconds counter.
//   mode_t  - operating mode, also driven out on the mode port
//   FIELD_W - width of each time field (matches the 0..63 digit converters)
//   SEC_MAX / MIN_MAX - last value before a seconds / minutes wrap
package hms_pkg;
    localparam int FIELD_W = 6;
    localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;
endpackage

// File: rtl/hms_time_counter_mod_counter.sv
// mod_counter: modulo-(MAX+1) up counter for one time field.
//   clk, rst - clock, synchronous active-high reset
//   en       - advance by one this cycle
//   clr      - force to zero (wins over en)
//   q        - current value, 0..MAX, registered
//   carry    - en && q==MAX; tells the next field to advance on the same edge
module mod_counter
    import hms_pkg::*;
#(
    parameter logic [FIELD_W-1:0] MAX = 6'd59
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    output logic [FIELD_W-1:0] q,
    output logic               carry
);
    logic [FIELD_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q == MAX) ? '0 : r_q + 1'b1;
        end
    end

    assign q     = r_q;
    assign carry = en && (r_q == MAX);
endmodule

// File: rtl/hms_time_counter.sv
// hms_time_counter: time-of-day counter with a two-button set mode.
//   clk, rst          - clock, synchronous active-high reset
//   btn_mode          - single-cycle pulse, RUN -> SET_HOUR -> SET_MIN -> RUN
//   btn_inc           - single-cycle pulse, bumps the field being set
//   hours             - 0..HOURS_MAX, registered
//   minutes, seconds  - 0..59, registered
//   sec_pulse         - one cycle per counted second, RUN only
//   mode              - current mode_t
//   blink             - first half of each second while setting, 0 in RUN
module hms_time_counter
    import hms_pkg::*;
#(
    parameter int TICKS_PER_SEC = 12000000,
    parameter int HOURS_MAX     = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_mode,
    input  logic               btn_inc,
    output logic [FIELD_W-1:0] hours,
    output logic [FIELD_W-1:0] minutes,
    output logic [FIELD_W-1:0] seconds,
    output logic               sec_pulse,
    output logic [1:0]         mode,
    output logic               blink
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICKS_PER_SEC / 2);

    mode_t          r_mode, w_mode_nxt;
    logic [PW-1:0]  r_presc, w_presc_nxt;
    logic           r_sec_pulse, r_blink;
    logic           w_tick, w_run, w_leave_set;
    logic           w_sec_en, w_min_en, w_hr_en;
    logic           w_sec_carry, w_min_carry, w_hr_carry_unused;

    assign w_tick      = (r_presc == PRE_LAST);
    assign w_run       = (r_mode == RUN);
    // Leaving SET_MIN restarts the second so the first tick is a full period away.
    assign w_leave_set = (r_mode == SET_MIN) && btn_mode;

    always_comb begin
        w_mode_nxt = r_mode;
        if (btn_mode) begin
            case (r_mode)
                RUN:      w_mode_nxt = SET_HOUR;
                SET_HOUR: w_mode_nxt = SET_MIN;
                default:  w_mode_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_mode <= RUN;
        else     r_mode <= w_mode_nxt;
    end

    assign w_presc_nxt = (w_leave_set || w_tick) ? '0 : r_presc + 1'b1;

    // Carries only chain in RUN; in set modes btn_inc drives one field alone,
    // and a mode press in the same cycle swallows it.
    assign w_sec_en = w_run && w_tick;
    assign w_min_en = w_run ? w_sec_carry
                            : ((r_mode == SET_MIN)  && btn_inc && !btn_mode);
    assign w_hr_en  = w_run ? w_min_carry
                            : ((r_mode == SET_HOUR) && btn_inc && !btn_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_sec_pulse <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            r_presc     <= w_presc_nxt;
            r_sec_pulse <= w_sec_en;
            // Built from next-state values so blink lines up with mode/prescaler.
            r_blink     <= (w_mode_nxt != RUN) && (w_presc_nxt < PRE_HALF);
        end
    end

    mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .en(w_sec_en), .clr(w_leave_set),
        .q(seconds), .carry(w_sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .en(w_min_en), .clr(1'b0),
        .q(minutes), .carry(w_min_carry)
    );

    mod_counter #(.MAX(FIELD_W'(HOURS_MAX))) u_hr (
        .clk(clk), .rst(rst), .en(w_hr_en), .clr(1'b0),
        .q(hours), .carry(w_hr_carry_unused)
    );

    assign sec_pulse = r_sec_pulse;
    assign mode      = r_mode;
    assign blink     = r_blink;
endmodule

// File: tb/tb_hms_time_counter.sv
module tb_hms_time_counter;
    localparam int TPS  = 4;
    localparam int HMAX = 23;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] hours, minutes, seconds;
    logic       sec_pulse, blink;
    logic [1:0] mode;

    hms_time_counter #(.TICKS_PER_SEC(TPS), .HOURS_MAX(HMAX)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .sec_pulse(sec_pulse), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int m; int s; int md; int pulse; int blink;
    } exp_t;

    typedef struct {
        int n; logic bm; logic bi; int h; int m; int md;
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   pulse_cnt = 0;

    // reference model state
    int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_presc = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected outputs.
    task automatic cyc(input logic r, input logic bm, input logic bi);
        exp_t e;
        int   t;
        bit   tick;
        @(negedge clk);
        rst = r; btn_mode = bm; btn_inc = bi;
        e.pulse = 0;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_presc = 0;
        end else begin
            tick = (m_presc == TPS - 1);
            case (m_mode)
                0: begin
                    if (tick) begin
                        t = (m_h * 3600 + m_m * 60 + m_s + 1) % ((HMAX + 1) * 3600);
                        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                        e.pulse = 1;
                    end
                    if (bm) m_mode = 1;
                    m_presc = tick ? 0 : m_presc + 1;
                end
                1: begin
                    if (bm) m_mode = 2;
                    else if (bi) m_h = (m_h + 1) % (HMAX + 1);
                    m_presc = tick ? 0 : m_presc + 1;
                end
                default: begin
                    if (bm) begin
                        m_mode = 0; m_s = 0; m_presc = 0;
                    end else begin
                        if (bi) m_m = (m_m + 1) % 60;
                        m_presc = tick ? 0 : m_presc + 1;
                    end
                end
            endcase
        end
        e.h = m_h; e.m = m_m; e.s = m_s; e.md = m_mode;
        e.blink = (m_mode != 0 && m_presc < TPS / 2) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: each queued expectation is compared just after the edge it belongs to.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_hours",   int'(hours),     e.h);
            chk("sb_minutes", int'(minutes),   e.m);
            chk("sb_seconds", int'(seconds),   e.s);
            chk("sb_mode",    int'(mode),      e.md);
            chk("sb_pulse",   int'(sec_pulse), e.pulse);
            chk("sb_blink",   int'(blink),     e.blink);
            chk("range",      int'(hours <= HMAX && minutes <= 59 && seconds <= 59), 1);
            if (sec_pulse) pulse_cnt++;
        end
    end

    initial begin
        vec_t tbl[11];
        int   found;

        // Set sequence starting at 00:01:00 in RUN.
        tbl[0]  = '{1,  1'b1, 1'b0, 0,  1,  1};
        tbl[1]  = '{40, 1'b0, 1'b0, 0,  1,  1};
        tbl[2]  = '{23, 1'b0, 1'b1, 23, 1,  1};
        tbl[3]  = '{1,  1'b0, 1'b1, 0,  1,  1};
        tbl[4]  = '{23, 1'b0, 1'b1, 23, 1,  1};
        tbl[5]  = '{1,  1'b1, 1'b0, 23, 1,  2};
        tbl[6]  = '{58, 1'b0, 1'b1, 23, 59, 2};
        tbl[7]  = '{1,  1'b0, 1'b1, 23, 0,  2};
        tbl[8]  = '{59, 1'b0, 1'b1, 23, 59, 2};
        tbl[9]  = '{2,  1'b0, 1'b0, 23, 59, 2};
        tbl[10] = '{1,  1'b1, 1'b1, 23, 59, 0};

        // Reset state.
        cyc(1, 0, 0);
        cyc(1, 1, 1);
        settle();
        chk("rst_hours", int'(hours), 0);
        chk("rst_mode",  int'(mode),  0);
        chk("rst_blink", int'(blink), 0);

        // 240 cycles of RUN: one full minute.
        pulse_cnt = 0;
        for (int i = 0; i < 240; i++) cyc(0, 0, 0);
        settle();
        chk("minute_pulses", pulse_cnt, 60);
        chk("minute_min",    int'(minutes), 1);
        chk("minute_sec",    int'(seconds), 0);

        // Table-driven set sequence.
        for (int v = 0; v < 11; v++) begin
            for (int k = 0; k < tbl[v].n; k++) cyc(0, tbl[v].bm, tbl[v].bi);
            settle();
            chk($sformatf("tbl%0d_hours", v),   int'(hours),   tbl[v].h);
            chk($sformatf("tbl%0d_minutes", v), int'(minutes), tbl[v].m);
            chk($sformatf("tbl%0d_mode", v),    int'(mode),    tbl[v].md);
        end
        chk("exit_seconds", int'(seconds), 0);

        // First second after leaving set mode is a full period long.
        found = 0;
        for (int k = 1; k <= 8 && found == 0; k++) begin
            cyc(0, 0, 0);
            settle();
            if (sec_pulse) found = k;
        end
        chk("exit_pulse_delay", found, 4);

        // Run up to 23:59:58 and through midnight.
        for (int i = 0; i < 228; i++) cyc(0, 0, 0);
        settle();
        chk("pre_h", int'(hours), 23);
        chk("pre_m", int'(minutes), 59);
        chk("pre_s", int'(seconds), 58);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);
        settle();
        chk("last_s", int'(seconds), 59);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        settle();
        chk("hold_h", int'(hours), 23);
        cyc(0, 0, 0);
        settle();
        chk("wrap_h", int'(hours), 0);
        chk("wrap_m", int'(minutes), 0);
        chk("wrap_s", int'(seconds), 0);

        // Set 12:34 and reset while in SET_MIN.
        cyc(0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1);
        cyc(0, 1, 0);
        for (int i = 0; i < 34; i++) cyc(0, 0, 1);
        settle();
        chk("set_h", int'(hours), 12);
        chk("set_m", int'(minutes), 34);
        chk("set_mode", int'(mode), 2);
        cyc(1, 0, 1);
        settle();
        chk("midrst_h",     int'(hours), 0);
        chk("midrst_m",     int'(minutes), 0);
        chk("midrst_mode",  int'(mode), 0);
        chk("midrst_blink", int'(blink), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        settle();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
